// File: rtl/mc_ctrl_pkg.sv
// Shared constants and enums for the multi-cycle MIPS control unit:
// opcode/funct encodings, ALU control codes, FSM states and instruction classes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b001;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB, BR, HALT
  } state_t;

  typedef enum logic [2:0] {
    RTYPE, ORI, LW, SW, BEQ, ILL
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Datapath <-> control bundle. master = control unit (drives selects/enables),
// slave = datapath (drives instruction word and ALU zero flag).
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             RegDst;
  logic             ALUSr;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemWrite;
  logic             nPC_sel;
  logic             ExtOp;
  logic [2:0]       ALUct;
  logic             PCWr;
  logic             IRWr;
  logic             retired;
  logic [CNT_W-1:0] retired_cnt;
  logic             illegal;

  modport master (
    input  instr, zero,
    output RegDst, ALUSr, MemtoReg, RegWrite, MemWrite, nPC_sel, ExtOp,
           ALUct, PCWr, IRWr, retired, retired_cnt, illegal
  );

  modport slave (
    output instr, zero,
    input  RegDst, ALUSr, MemtoReg, RegWrite, MemWrite, nPC_sel, ExtOp,
           ALUct, PCWr, IRWr, retired, retired_cnt, illegal
  );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational opcode/funct -> instruction-class decoder.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output iclass_t    cls
);

  always_comb begin
    cls = ILL;
    case (op)
      OP_RTYPE: if (fn == FN_ADDU || fn == FN_SUBU) cls = RTYPE;
      OP_ORI:   cls = ORI;
      OP_LW:    cls = LW;
      OP_SW:    cls = SW;
      OP_BEQ:   cls = BEQ;
      default:  cls = ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define MC_ILLEGAL_TRAP_EN to trap illegal instructions in a sticky HALT state.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d, fn_q, fn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       dec_op, dec_fn;
  iclass_t          cls;
  logic             ret;

  // The IR is only valid from DECODE, so decode it live there and from the latched copy afterwards.
  assign dec_op = (state_q == DECODE) ? bus.instr[31:26] : op_q;
  assign dec_fn = (state_q == DECODE) ? bus.instr[5:0]   : fn_q;

  mc_ctrl_dec u_dec (
    .op  (dec_op),
    .fn  (dec_fn),
    .cls (cls)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fn_d         = fn_q;
    ret          = 1'b0;
    bus.RegDst   = 1'b0;
    bus.ALUSr    = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.nPC_sel  = 1'b0;
    bus.ExtOp    = 1'b0;
    bus.ALUct    = 3'b000;
    bus.PCWr     = 1'b0;
    bus.IRWr     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.IRWr = 1'b1;
        bus.PCWr = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        op_d = bus.instr[31:26];
        fn_d = bus.instr[5:0];
        case (cls)
          BEQ: state_d = BR;
          ILL: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = HALT;
`else
            state_d = FETCH;
            ret     = 1'b1;
`endif
          end
          default: state_d = EXE;
        endcase
      end
      EXE, MEM_RD, MEM_WR, WB: begin
        // Selects stay stable from EXE through the last state of the instruction.
        case (cls)
          RTYPE:   bus.ALUct = (fn_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
          ORI: begin
            bus.ALUSr = 1'b1;
            bus.ALUct = ALU_OR;
          end
          default: begin
            bus.ALUSr = 1'b1;
            bus.ExtOp = 1'b1;
            bus.ALUct = ALU_ADD;
          end
        endcase
        case (state_q)
          EXE:     state_d = (cls == LW) ? MEM_RD : (cls == SW) ? MEM_WR : WB;
          MEM_RD:  state_d = WB;
          MEM_WR: begin
            bus.MemWrite = 1'b1;
            ret          = 1'b1;
            state_d      = FETCH;
          end
          default: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = (cls == RTYPE);
            bus.MemtoReg = (cls == LW);
            ret          = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end
      BR: begin
        bus.ALUct   = ALU_SUB;
        bus.nPC_sel = 1'b1;
        bus.PCWr    = bus.zero;
        bus.ExtOp   = 1'b1;
        ret         = 1'b1;
        state_d     = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    if (reset) begin
      bus.PCWr     = 1'b0;
      bus.IRWr     = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
      ret          = 1'b0;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, ret};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    op_q <= op_d;
    fn_q <= fn_d;
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == HALT);

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.retired     = ret;
  assign bus.retired_cnt = cnt_q;

endmodule
